cnn_layer_sched: RTL and testbench
==================================

Name: cnn_layer_sched

Overview:
Layer sequencer for the CNN convolution engine.
- Accepts image and weight words from a host valid/ready stream and writes them into the image RAM and weight RAM write ports.
- Presents per-layer W/H/C and cnn_state, and raises convStart.
- Waits for the engine's convFinish, then advances to the next layer until all layers are done.
- Sits between the host loader and the conv engine. It owns both RAM write ports; the engine owns the read ports.

Parameters:
NUM_LAYERS, 3, number of layers sequenced (1..7).
WGT_WORDS, 25, weight words per layer (5x5 kernel, channels packed per 128-bit word).
DW, 128, RAM data width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run from layer 0
s_valid  in  1  host word valid
s_ready  out  1  host word accepted when s_valid&s_ready
s_data  in  DW  host word (signed)
convStart  out  1  level; conv engine may run
convFinish  in  1  engine done (level or pulse, asynchronous domain tolerated)
cnn_state  out  3  0 idle, else current layer index+1
W  out  6  current layer width
H  out  6  current layer height
C  out  5  current layer channels
done  out  1  one-cycle pulse after last layer finishes
ramImage_en  out  1  image RAM enable
ramImage_we  out  1  image RAM write enable
ramImage_addrW  out  10  image RAM write address
ramImage_din  out  DW  image RAM write data
ramWeight_en  out  1  weight RAM enable
ramWeight_we  out  1  weight RAM write enable
ramWeight_addrW  out  5  weight RAM write address
ramWeight_din  out  DW  weight RAM write data

Behaviour:
- Single clock domain clk. Reset is asynchronous and active-low on rst_n. All outputs are registered except s_ready.
- Reset values:
  - state IDLE; layer 0; cnt 0.
  - All RAM en/we/addr/din 0; convStart 0; done 0.
  - cnn_state 0; W/H/C 0.
  - convFinish synchroniser 2'b00.
- FSM states: IDLE, LOAD_I, LOAD_W, CONV, DONE.
- IDLE:
  - start=1: layer<=0; load W/H/C from table entry 0; cnt<=0; go to LOAD_I.
  - start in any other state is ignored.
- s_ready = (state==LOAD_I or LOAD_W), combinational.
- Image load:
  - Accepted word in LOAD_I: next cycle ramImage_en=ramImage_we=1, addrW=cnt, din=s_data; cnt++.
  - Otherwise en/we=0 next cycle.
  - Last image word is cnt==W*H-1 (computed 12-bit; table guarantees W*H<=1024). On acceptance: cnt<=0, go to LOAD_W.
- Weight load:
  - LOAD_W writes the weight port the same way.
  - Last word is cnt==WGT_WORDS-1. On acceptance: cnt<=0, go to CONV.
- Layers >0 skip LOAD_I; image data comes from engine writeback.
- CONV:
  - convStart=1 from the first CONV cycle.
  - convFinish is 2-flop registered; the rising edge (r[0]&~r[1]) is the finish event.
  - Edges outside CONV are discarded. The synchroniser still runs, so an early level does not count twice.
- On a finish event in CONV, convStart<=0, then:
  - layer==NUM_LAYERS-1: go to DONE.
  - otherwise: layer++, load W/H/C of the next layer, go to LOAD_W.
- DONE: done=1 for one cycle, cnn_state<=0, go to IDLE. W/H/C hold their last values.
- cnn_state = layer+1 in every state except IDLE and DONE's exit.
- s_valid low mid-load: addr holds, no write, no timeout.
- Reset mid-operation: immediate return to reset values. Partially written RAM content is not scrubbed.

Decomposition:
- Package cnn_pkg holds:
  - state enum.
  - Layer table constants LAYER_W/H/C[NUM_LAYERS]: {32,32,1},{28,28,6},{24,24,6}.
  - Widths IMG_AW=10, WGT_AW=5.
- One natural sub-module: cnn_edge_sync (2-flop synchroniser plus rising-edge detect), reusable for other engine status lines.

Test Plan:
- Reset then start; stream 1024 image words (data=index), then 25 weights -> image addr 0..1023 with din=addr, weight addr 0..24 written; convStart rises in the cycle after the 1049th accept; cnn_state=1, W=32, H=32, C=1.
- Hold s_valid low for 5 cycles mid-image at word 500 -> no writes; resumes at addr 500; no gaps or duplicates.
- In CONV, pulse convFinish -> convStart falls about 3 cycles later; cnn_state=2, W=28, C=6, s_ready=1; exactly 25 weight writes follow, with no image writes.
- Complete all 3 layers -> single done pulse after the third finish edge; cnn_state returns to 0; a second start reruns from layer 0.
- Hold convFinish high during LOAD_W, then low, then pulse in CONV -> only the CONV pulse advances; start pulses during loads are ignored.
- Assert rst_n low during layer-1 CONV -> all outputs at reset values asynchronously; a new start begins at LOAD_I, layer 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and layer geometry for the CNN layer sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_I = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_CONV   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int IMG_AW = 10;
  localparam int WGT_AW = 5;

  // Eight entries so a 3-bit layer index can never run off the table; unused rows repeat the last layer.
  localparam int TABLE_DEPTH = 8;

  localparam logic [5:0] LAYER_W [TABLE_DEPTH] = '{6'd32, 6'd28, 6'd24, 6'd24, 6'd24, 6'd24, 6'd24, 6'd24};
  localparam logic [5:0] LAYER_H [TABLE_DEPTH] = '{6'd32, 6'd28, 6'd24, 6'd24, 6'd24, 6'd24, 6'd24, 6'd24};
  localparam logic [4:0] LAYER_C [TABLE_DEPTH] = '{5'd1,  5'd6,  5'd6,  5'd6,  5'd6,  5'd6,  5'd6,  5'd6};

  function automatic logic [11:0] img_words(input logic [5:0] w, input logic [5:0] h);
    return {6'd0, w} * {6'd0, h};
  endfunction

endpackage

// File: rtl/cnn_edge_sync.sv
// Two-flop synchroniser with rising-edge detect for engine status lines.
module cnn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [1:0] sync_r;

  // Shift the asynchronous level through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], din};
    end
  end

  assign rise = sync_r[0] & ~sync_r[1];

endmodule

// File: rtl/cnn_layer_sched.sv
// Layer sequencer: loads image/weight RAMs from the host stream and hands each layer to the conv engine.
module cnn_layer_sched
  import cnn_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int WGT_WORDS  = 25,
  parameter int DW         = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic              convStart,
  input  logic              convFinish,
  output logic [2:0]        cnn_state,
  output logic [5:0]        W,
  output logic [5:0]        H,
  output logic [4:0]        C,
  output logic              done,
  output logic              ramImage_en,
  output logic              ramImage_we,
  output logic [IMG_AW-1:0] ramImage_addrW,
  output logic [DW-1:0]     ramImage_din,
  output logic              ramWeight_en,
  output logic              ramWeight_we,
  output logic [WGT_AW-1:0] ramWeight_addrW,
  output logic [DW-1:0]     ramWeight_din
);

  state_t              state_r, state_nxt;
  logic [2:0]          layer_r, layer_nxt;
  logic [IMG_AW-1:0]   cnt_r, cnt_nxt;
  logic                fin_evt_s, accept_s, img_last_s, wgt_last_s, last_layer_s;
  logic [2:0]          next_layer_s;
  logic                conv_start_nxt, done_nxt, img_wr_r, img_wr_nxt, wgt_wr_r, wgt_wr_nxt;
  logic [2:0]          cnn_state_nxt;
  logic [5:0]          w_nxt, h_nxt;
  logic [4:0]          c_nxt;
  logic [IMG_AW-1:0]   img_addr_nxt;
  logic [WGT_AW-1:0]   wgt_addr_nxt;
  logic [DW-1:0]       img_din_nxt, wgt_din_nxt;

  cnn_edge_sync u_fin_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (convFinish),
    .rise  (fin_evt_s)
  );

  assign s_ready      = (state_r == ST_LOAD_I) || (state_r == ST_LOAD_W);
  assign accept_s     = s_valid & s_ready;
  assign img_last_s   = ({2'b00, cnt_r} == (img_words(W, H) - 12'd1));
  assign wgt_last_s   = (cnt_r == IMG_AW'(WGT_WORDS - 1));
  assign last_layer_s = (layer_r == 3'(NUM_LAYERS - 1));
  assign next_layer_s = layer_r + 3'd1;

  assign ramImage_en  = img_wr_r;
  assign ramImage_we  = img_wr_r;
  assign ramWeight_en = wgt_wr_r;
  assign ramWeight_we = wgt_wr_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; only layer 0 passes through the image load.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:   if (start) state_nxt = ST_LOAD_I; else state_nxt = ST_IDLE;
      ST_LOAD_I: if (accept_s && img_last_s) state_nxt = ST_LOAD_W; else state_nxt = ST_LOAD_I;
      ST_LOAD_W: if (accept_s && wgt_last_s) state_nxt = ST_CONV; else state_nxt = ST_LOAD_W;
      ST_CONV: begin
        if (fin_evt_s) begin
          if (last_layer_s) state_nxt = ST_DONE; else state_nxt = ST_LOAD_W;
        end else begin
          state_nxt = ST_CONV;
        end
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath counters.
  always_comb begin
    layer_nxt      = layer_r;
    cnt_nxt        = cnt_r;
    conv_start_nxt = convStart;
    done_nxt       = 1'b0;
    cnn_state_nxt  = cnn_state;
    w_nxt          = W;
    h_nxt          = H;
    c_nxt          = C;
    img_wr_nxt     = 1'b0;
    img_addr_nxt   = ramImage_addrW;
    img_din_nxt    = ramImage_din;
    wgt_wr_nxt     = 1'b0;
    wgt_addr_nxt   = ramWeight_addrW;
    wgt_din_nxt    = ramWeight_din;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          layer_nxt     = 3'd0;
          cnt_nxt       = {IMG_AW{1'b0}};
          cnn_state_nxt = 3'd1;
          w_nxt         = LAYER_W[0];
          h_nxt         = LAYER_H[0];
          c_nxt         = LAYER_C[0];
        end else begin
          layer_nxt = layer_r;
        end
      end
      ST_LOAD_I: begin
        if (accept_s) begin
          img_wr_nxt   = 1'b1;
          img_addr_nxt = cnt_r;
          img_din_nxt  = s_data;
          if (img_last_s) cnt_nxt = {IMG_AW{1'b0}}; else cnt_nxt = cnt_r + 10'd1;
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      ST_LOAD_W: begin
        if (accept_s) begin
          wgt_wr_nxt   = 1'b1;
          wgt_addr_nxt = cnt_r[WGT_AW-1:0];
          wgt_din_nxt  = s_data;
          if (wgt_last_s) begin
            cnt_nxt        = {IMG_AW{1'b0}};
            conv_start_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_r + 10'd1;
          end
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      ST_CONV: begin
        if (fin_evt_s) begin
          conv_start_nxt = 1'b0;
          if (!last_layer_s) begin
            layer_nxt     = next_layer_s;
            cnn_state_nxt = next_layer_s + 3'd1;
            w_nxt         = LAYER_W[next_layer_s];
            h_nxt         = LAYER_H[next_layer_s];
            c_nxt         = LAYER_C[next_layer_s];
          end else begin
            layer_nxt = layer_r;
          end
        end else begin
          conv_start_nxt = convStart;
        end
      end
      ST_DONE: begin
        done_nxt      = 1'b1;
        cnn_state_nxt = 3'd0;
      end
      default: begin
        done_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_r         <= 3'd0;
      cnt_r           <= {IMG_AW{1'b0}};
      convStart       <= 1'b0;
      done            <= 1'b0;
      cnn_state       <= 3'd0;
      W               <= 6'd0;
      H               <= 6'd0;
      C               <= 5'd0;
      img_wr_r        <= 1'b0;
      ramImage_addrW  <= {IMG_AW{1'b0}};
      ramImage_din    <= {DW{1'b0}};
      wgt_wr_r        <= 1'b0;
      ramWeight_addrW <= {WGT_AW{1'b0}};
      ramWeight_din   <= {DW{1'b0}};
    end else begin
      layer_r         <= layer_nxt;
      cnt_r           <= cnt_nxt;
      convStart       <= conv_start_nxt;
      done            <= done_nxt;
      cnn_state       <= cnn_state_nxt;
      W               <= w_nxt;
      H               <= h_nxt;
      C               <= c_nxt;
      img_wr_r        <= img_wr_nxt;
      ramImage_addrW  <= img_addr_nxt;
      ramImage_din    <= img_din_nxt;
      wgt_wr_r        <= wgt_wr_nxt;
      ramWeight_addrW <= wgt_addr_nxt;
      ramWeight_din   <= wgt_din_nxt;
    end
  end

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Randomised bench for cnn_layer_sched: a per-cycle behavioural model plus literal spot checks.
module tb_cnn_layer_sched;

  localparam int DW = 128;
  localparam int NL = 3;
  localparam int WG = 25;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, convFinish = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, convStart, done;
  logic [2:0]    cnn_state;
  logic [5:0]    W, H;
  logic [4:0]    C;
  logic          ramImage_en, ramImage_we, ramWeight_en, ramWeight_we;
  logic [9:0]    ramImage_addrW;
  logic [4:0]    ramWeight_addrW;
  logic [DW-1:0] ramImage_din, ramWeight_din;

  cnn_layer_sched #(.NUM_LAYERS(NL), .WGT_WORDS(WG), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .convStart(convStart), .convFinish(convFinish), .cnn_state(cnn_state), .W(W), .H(H), .C(C),
    .done(done), .ramImage_en(ramImage_en), .ramImage_we(ramImage_we), .ramImage_addrW(ramImage_addrW),
    .ramImage_din(ramImage_din), .ramWeight_en(ramWeight_en), .ramWeight_we(ramWeight_we),
    .ramWeight_addrW(ramWeight_addrW), .ramWeight_din(ramWeight_din)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int img_wr = 0, wgt_wr = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 image load, 2 weight load, 3 convolving, 4 wrap-up.
  logic [5:0]    tw [NL] = '{6'd32, 6'd28, 6'd24};
  logic [5:0]    th [NL] = '{6'd32, 6'd28, 6'd24};
  logic [4:0]    tc [NL] = '{5'd1, 5'd6, 5'd6};
  int            m_phase = 0, m_layer = 0, m_words = 0;
  logic          f_prev1 = 1'b0, f_prev2 = 1'b0;
  logic          e_conv = 1'b0, e_done = 1'b0, e_img_wr = 1'b0, e_wgt_wr = 1'b0;
  logic [2:0]    e_state = 3'd0;
  logic [5:0]    e_w = 6'd0, e_h = 6'd0;
  logic [4:0]    e_c = 5'd0;
  logic [9:0]    e_img_addr = 10'd0;
  logic [4:0]    e_wgt_addr = 5'd0;
  logic [DW-1:0] e_img_din = '0, e_wgt_din = '0;

  task automatic model_reset();
    m_phase = 0; m_layer = 0; m_words = 0; f_prev1 = 1'b0; f_prev2 = 1'b0;
    e_conv = 1'b0; e_done = 1'b0; e_img_wr = 1'b0; e_wgt_wr = 1'b0; e_state = 3'd0;
    e_w = 6'd0; e_h = 6'd0; e_c = 5'd0; e_img_addr = 10'd0; e_wgt_addr = 5'd0;
    e_img_din = '0; e_wgt_din = '0;
  endtask

  task automatic use_layer(input int l);
    m_layer = l; e_w = tw[l]; e_h = th[l]; e_c = tc[l]; e_state = 3'(l + 1);
  endtask

  task automatic model_step();
    logic finished;
    // A finish counts when the level seen one edge ago was high and the one before was low.
    finished = f_prev1 & ~f_prev2;
    f_prev2 = f_prev1;
    f_prev1 = convFinish;
    e_img_wr = 1'b0; e_wgt_wr = 1'b0; e_done = 1'b0;
    case (m_phase)
      0: if (start) begin use_layer(0); m_words = 0; m_phase = 1; end
      1: if (s_valid) begin
        e_img_wr = 1'b1; e_img_addr = m_words[9:0]; e_img_din = s_data; m_words++;
        if (m_words == int'(e_w) * int'(e_h)) begin m_words = 0; m_phase = 2; end
      end
      2: if (s_valid) begin
        e_wgt_wr = 1'b1; e_wgt_addr = m_words[4:0]; e_wgt_din = s_data; m_words++;
        if (m_words == WG) begin m_words = 0; m_phase = 3; e_conv = 1'b1; end
      end
      3: if (finished) begin
        e_conv = 1'b0;
        if (m_layer == NL - 1) m_phase = 4;
        else begin use_layer(m_layer + 1); m_phase = 2; end
      end
      4: begin e_done = 1'b1; e_state = 3'd0; m_phase = 0; end
      default: m_phase = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("ctrl {rdy,cs,done,st,W,H,C}", {s_ready, convStart, done, cnn_state, W, H, C},
        {(m_phase == 1 || m_phase == 2), e_conv, e_done, e_state, e_w, e_h, e_c});
    chk("img port {en,we,addr,din}", {ramImage_en, ramImage_we, ramImage_addrW, ramImage_din},
        {e_img_wr, e_img_wr, e_img_addr, e_img_din});
    chk("wgt port {en,we,addr,din}", {ramWeight_en, ramWeight_we, ramWeight_addrW, ramWeight_din},
        {e_wgt_wr, e_wgt_wr, e_wgt_addr, e_wgt_din});
  end

  initial forever begin
    @(negedge clk);
    if (ramImage_en && ramImage_we) img_wr++;
    if (ramWeight_en && ramWeight_we) wgt_wr++;
    if (done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_cycles(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int   tries = 0;
    logic rdy;
    s_valid = 1'b1;
    s_data  = d;
    rdy = s_ready;
    @(negedge clk);
    while (!rdy && tries < 50) begin
      rdy = s_ready;
      tries++;
      @(negedge clk);
    end
    if (!rdy) chk("send_word ready timeout", 1'b0, 1'b1);
    s_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stream n words; gap_at inserts a 5-cycle valid-low hole, start_at pulses start mid-load.
  task automatic load_words(input int n, input bit index_data, input int gap_at, input int start_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) idle_cycles(5);
      else if ($urandom_range(0, 15) == 0) idle_cycles(1);
      if (i == start_at) start = 1'b1;
      send_word(index_data && i < 1024 ? DW'(i) : rnd_word());
      start = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    convFinish = 1'b1;
    @(negedge clk);
    convFinish = 1'b0;
  endtask

  task automatic wait_conv_low();
    int n = 0;
    while (convStart && n < 20) begin @(negedge clk); n++; end
    chk("convStart falls after finish", convStart, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset s_ready", s_ready, 1'b0);
    chk("reset cnn_state", cnn_state, 3'd0);
    chk("reset W", W, 6'd0);
    chk("reset convStart", convStart, 1'b0);

    // Run 1, layer 0: 1024 image words (data = index) with a hole at word 500, then 25 weights.
    pulse_start();
    chk("start cnn_state", cnn_state, 3'd1);
    chk("start s_ready", s_ready, 1'b1);
    img_wr = 0; wgt_wr = 0;
    load_words(1024 + WG, 1'b1, 500, -1);
    chk("convStart after 1049th accept", convStart, 1'b1);
    idle_cycles(2);
    chk("layer0 image writes", img_wr, 32'd1024);
    chk("layer0 weight writes", wgt_wr, 32'd25);
    chk("layer0 W", W, 6'd32);
    chk("layer0 H", H, 6'd32);
    chk("layer0 C", C, 5'd1);
    chk("layer0 last image din", ramImage_din, 128'd1023);

    // Finish layer 0; layer 1 loads weights only, with convFinish held high and a stray start.
    idle_cycles(3);
    pulse_finish();
    wait_conv_low();
    chk("layer1 cnn_state", cnn_state, 3'd2);
    chk("layer1 W", W, 6'd28);
    chk("layer1 C", C, 5'd6);
    chk("layer1 s_ready", s_ready, 1'b1);
    img_wr = 0; wgt_wr = 0;
    convFinish = 1'b1;
    load_words(12, 1'b0, -1, 5);
    convFinish = 1'b0;
    load_words(WG - 12, 1'b0, -1, -1);
    idle_cycles(6);
    chk("layer1 image writes", img_wr, 32'd0);
    chk("layer1 weight writes", wgt_wr, 32'd25);
    chk("early finish level ignored", convStart, 1'b1);
    chk("still layer1", cnn_state, 3'd2);

    pulse_finish();
    wait_conv_low();
    chk("layer2 cnn_state", cnn_state, 3'd3);
    chk("layer2 W", W, 6'd24);
    load_words(WG, 1'b0, -1, -1);
    idle_cycles(3);
    done_cnt = 0;
    pulse_finish();
    for (int n = 0; n < 20 && !done; n++) @(negedge clk);
    chk("done seen", done, 1'b1);
    idle_cycles(4);
    chk("single done pulse", done_cnt, 32'd1);
    chk("cnn_state after done", cnn_state, 3'd0);
    chk("W held after done", W, 6'd24);

    // Run 2 with random data, then reset asynchronously during layer-1 convolution.
    pulse_start();
    chk("rerun cnn_state", cnn_state, 3'd1);
    chk("rerun W", W, 6'd32);
    load_words(1024 + WG, 1'b0, -1, -1);
    idle_cycles(3);
    pulse_finish();
    wait_conv_low();
    load_words(WG, 1'b0, -1, -1);
    idle_cycles(4);
    chk("run2 layer1 conv", {convStart, cnn_state}, {1'b1, 3'd2});
    #2 rst_n = 1'b0;
    #1;
    chk("async reset convStart", convStart, 1'b0);
    chk("async reset cnn_state", cnn_state, 3'd0);
    chk("async reset W", W, 6'd0);
    chk("async reset weight addr", ramWeight_addrW, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    pulse_start();
    chk("post-reset cnn_state", cnn_state, 3'd1);
    chk("post-reset s_ready", s_ready, 1'b1);
    load_words(40, 1'b1, -1, -1);
    idle_cycles(1);
    chk("post-reset last image addr", ramImage_addrW, 10'd39);
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
